// File: rtl/apb_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_cmd_master_pkg
//   Shared APB definitions: transfer state encodings and the default ACCESS
//   phase timeout used by the APB blocks.
// -----------------------------------------------------------------------------
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

  localparam int APB_DEFAULT_TIMEOUT = 256;

endpackage : apb_cmd_master_pkg

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//   Converts a valid/ready command into a single APB transfer and returns the
//   result on a valid/ready response channel. An ACCESS phase that lasts
//   TIMEOUT cycles without m_pready is aborted and reported as a timeout.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | m_psel=1, m_penable=0 for one cycle
//   ACCESS | m_psel=1, m_penable=1 until m_pready or timeout
//   RESP   | rsp_valid high, payload held until rsp_ready
//
// Ports
//   pclk, preset_n                      clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_write, cmd_addr, cmd_wdata      command payload
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err, rsp_timeout     response payload
//   m_paddr, m_pwrite, m_psel,
//   m_penable, m_pwdata                 APB master request outputs
//   m_prdata, m_pready, m_pslverr       APB completer inputs
// -----------------------------------------------------------------------------
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT  = APB_DEFAULT_TIMEOUT,
  parameter int CNT_BITS = 9
) (
  input  logic        pclk,
  input  logic        preset_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,

  output logic [31:0] m_paddr,
  output logic        m_pwrite,
  output logic        m_psel,
  output logic        m_penable,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  localparam bit                TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_BITS-1:0] TO_LAST = TO_EN ? CNT_BITS'(TIMEOUT - 1) : '0;

  apb_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tout_q, tout_d;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= APB_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tout_q      <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;

    unique case (state_q)
      APB_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = APB_SETUP;
        end
      end
      APB_SETUP: begin
        cnt_d   = '0;
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        // m_pready wins over a timeout that would fire on the same cycle
        if (m_pready) begin
          rdata_d = pwrite_q ? 32'h0 : m_prdata;
          err_d   = m_pslverr;
          tout_d  = 1'b0;
          state_d = APB_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = APB_RESP;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      APB_RESP: begin
        if (rsp_ready) state_d = APB_IDLE;
      end
      default: state_d = APB_IDLE;
    endcase

    // Outputs are registered copies of the next state so they are glitch
    // free and still clear asynchronously with preset_n.
    psel_d      = (state_d == APB_SETUP) || (state_d == APB_ACCESS);
    penable_d   = (state_d == APB_ACCESS);
    cmd_ready_d = (state_d == APB_IDLE);
    rsp_valid_d = (state_d == APB_RESP);
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tout_q;
  assign m_paddr     = paddr_q;
  assign m_pwrite    = pwrite_q;
  assign m_pwdata    = pwdata_q;
  assign m_psel      = psel_q;
  assign m_penable   = penable_q;

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        preset_n;

  // main instance, default TIMEOUT
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pwrite, m_psel, m_penable, m_pready, m_pslverr;

  // timeout instance, TIMEOUT=4
  logic        cmd_valid_t, cmd_ready_t, cmd_write_t;
  logic [31:0] cmd_addr_t, cmd_wdata_t;
  logic        rsp_valid_t, rsp_ready_t, rsp_err_t, rsp_timeout_t;
  logic [31:0] rsp_rdata_t;
  logic [31:0] m_paddr_t, m_pwdata_t, m_prdata_t;
  logic        m_pwrite_t, m_psel_t, m_penable_t, m_pready_t, m_pslverr_t;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_cmd_master dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel),
    .m_penable(m_penable), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  apb_cmd_master #(.TIMEOUT(4), .CNT_BITS(3)) dut_t (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_write(cmd_write_t),
    .cmd_addr(cmd_addr_t), .cmd_wdata(cmd_wdata_t),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_rdata(rsp_rdata_t),
    .rsp_err(rsp_err_t), .rsp_timeout(rsp_timeout_t),
    .m_paddr(m_paddr_t), .m_pwrite(m_pwrite_t), .m_psel(m_psel_t),
    .m_penable(m_penable_t), .m_pwdata(m_pwdata_t), .m_prdata(m_prdata_t),
    .m_pready(m_pready_t), .m_pslverr(m_pslverr_t)
  );

  // m_penable must never be high without m_psel
  always @(negedge pclk) begin
    if (preset_n) begin
      checks++;
      if ((m_penable && !m_psel) || (m_penable_t && !m_psel_t)) begin
        errors++;
        $display("FAIL penable_without_psel: penable=%b/%b psel=%b/%b expected psel high",
                 m_penable, m_penable_t, m_psel, m_psel_t);
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Slave model: holds m_pready low for 'waits' ACCESS cycles, then completes.
  // Addresses at or above 0x800 are outside the two 1K decoder ports.
  task automatic run_access(input int waits, input logic [31:0] rd,
                            input logic [31:0] exp_addr, output int pen);
    pen = 0; m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) break;
      if (m_penable === 1'b1) begin
        pen++;
        checks++;
        if (m_paddr !== exp_addr) begin
          errors++; $display("FAIL paddr_hold: got %h expected %h", m_paddr, exp_addr);
        end
        if (pen == waits + 1) begin
          m_pready = 1'b1; m_prdata = rd; m_pslverr = (m_paddr >= 32'h800);
        end
      end
      tick();
    end
    m_pready = 1'b0; m_pslverr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_wait: rsp_valid=%b expected 1", rsp_valid);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    m_prdata = 0; m_pready = 0; m_pslverr = 0;
    cmd_valid_t = 0; cmd_write_t = 0; cmd_addr_t = 0; cmd_wdata_t = 0; rsp_ready_t = 0;
    m_prdata_t = 0; m_pready_t = 0; m_pslverr_t = 0;
    #12;
    checks++;
    if ({m_psel, m_penable, rsp_valid, rsp_err, rsp_timeout, m_pwrite} !== 6'b0 ||
        m_paddr !== 32'h0 || m_pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b pen=%b rv=%b err=%b to=%b paddr=%h rdata=%h expected all 0",
               m_psel, m_penable, rsp_valid, rsp_err, rsp_timeout, m_paddr, rsp_rdata);
    end
    preset_n = 1'b1;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready_t !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b/%b expected 1/1", cmd_ready, cmd_ready_t);
    end
  endtask

  task automatic test_write_zero_wait();
    m_pready = 1'b1; m_prdata = 32'hAAAA5555; m_pslverr = 1'b0;
    send_cmd(1'b1, 32'h400, 32'hDEADBEEF);
    // cycle 1: SETUP
    checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h400 ||
        m_pwrite !== 1'b1 || m_pwdata !== 32'hDEADBEEF || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_setup: psel=%b pen=%b addr=%h wr=%b wdata=%h rdy=%b expected 1 0 400 1 deadbeef 0",
               m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, cmd_ready);
    end
    tick();
    // cycle 2: ACCESS
    checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b1 || rsp_valid !== 1'b0 || m_pwdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_access: psel=%b pen=%b rv=%b expected 1 1 0", m_psel, m_penable, rsp_valid);
    end
    tick();
    m_pready = 1'b0;
    // cycle 3: RESP
    checks++;
    if (rsp_valid !== 1'b1 || m_psel !== 1'b0 || m_penable !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp: rv=%b psel=%b err=%b to=%b rdata=%h rdy=%b expected 1 0 0 0 0 0",
               rsp_valid, m_psel, rsp_err, rsp_timeout, rsp_rdata, cmd_ready);
    end
    finish_rsp();
  endtask

  task automatic test_read_waits();
    int pen;
    send_cmd(1'b0, 32'h404, 32'h0);
    run_access(5, 32'h12345678, 32'h404, pen);
    checks++;
    if (pen != 6) begin errors++; $display("FAIL rd_pen_cycles: got %0d expected 6", pen); end
    checks++;
    if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL rd_payload: rdata=%h err=%b to=%b expected 12345678 0 0",
                         rsp_rdata, rsp_err, rsp_timeout);
    end
    finish_rsp();
  endtask

  task automatic test_slverr();
    int pen;
    send_cmd(1'b0, 32'h0000_0C00, 32'h0);
    run_access(0, 32'h0BAD0BAD, 32'h0000_0C00, pen);
    checks++;
    if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || pen != 1) begin
      errors++; $display("FAIL slverr: err=%b to=%b pen=%0d expected 1 0 1", rsp_err, rsp_timeout, pen);
    end
    finish_rsp();
  endtask

  // waits < 0: slave never responds
  task automatic run_t(input int waits, input logic [31:0] rd, output int pen);
    int n = 0;
    pen = 0; m_pready_t = 1'b0; m_prdata_t = 32'h11111111;
    while (cmd_ready_t !== 1'b1 && n < 10) begin tick(); n++; end
    cmd_valid_t = 1'b1; cmd_write_t = 1'b0; cmd_addr_t = 32'h100;
    tick();
    cmd_valid_t = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid_t === 1'b1) break;
      if (m_penable_t === 1'b1) begin
        pen++;
        if (waits >= 0 && pen == waits + 1) begin m_pready_t = 1'b1; m_prdata_t = rd; end
      end
      tick();
    end
    m_pready_t = 1'b0;
    checks++;
    if (rsp_valid_t !== 1'b1) begin
      errors++; $display("FAIL t_rsp_wait: rsp_valid=%b expected 1", rsp_valid_t);
    end
  endtask

  task automatic test_timeout();
    int pen;
    run_t(-1, 32'h0, pen);
    checks++;
    if (pen != 4) begin errors++; $display("FAIL to_pen_cycles: got %0d expected 4", pen); end
    checks++;
    if (rsp_err_t !== 1'b1 || rsp_timeout_t !== 1'b1 || rsp_rdata_t !== 32'h0 ||
        m_psel_t !== 1'b0 || m_penable_t !== 1'b0) begin
      errors++; $display("FAIL to_payload: err=%b to=%b rdata=%h psel=%b pen=%b expected 1 1 0 0 0",
                         rsp_err_t, rsp_timeout_t, rsp_rdata_t, m_psel_t, m_penable_t);
    end
    rsp_ready_t = 1'b1; tick(); rsp_ready_t = 1'b0;
  endtask

  // pready arrives on the last cycle before the timeout would fire
  task automatic test_timeout_boundary();
    int pen;
    run_t(3, 32'h0BADCAFE, pen);
    checks++;
    if (pen != 4 || rsp_err_t !== 1'b0 || rsp_timeout_t !== 1'b0 || rsp_rdata_t !== 32'h0BADCAFE) begin
      errors++; $display("FAIL to_boundary: pen=%0d err=%b to=%b rdata=%h expected 4 0 0 0badcafe",
                         pen, rsp_err_t, rsp_timeout_t, rsp_rdata_t);
    end
    rsp_ready_t = 1'b1; tick(); rsp_ready_t = 1'b0;
  endtask

  task automatic test_backpressure();
    int pen;
    int bad = 0;
    send_cmd(1'b0, 32'h008, 32'h0);
    run_access(1, 32'hCAFEF00D, 32'h008, pen);
    m_prdata = 32'hFFFFFFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3FC;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || m_psel !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL backpressure: %0d bad cycles, rv=%b rdata=%h rdy=%b psel=%b expected 1 cafef00d 0 0",
                         bad, rsp_valid, rsp_rdata, cmd_ready, m_psel);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL resp_exit_ready: cmd_ready=%b expected 0", cmd_ready);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_psel !== 1'b0) begin
      errors++; $display("FAIL bp_release: rv=%b rdy=%b psel=%b expected 0 1 0", rsp_valid, cmd_ready, m_psel);
    end
  endtask

  task automatic test_reset_mid();
    int pen;
    int seen = 0;
    m_pready = 1'b0;
    send_cmd(1'b0, 32'h010, 32'h0);
    tick();
    checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b1) begin
      errors++; $display("FAIL mid_access: psel=%b pen=%b expected 1 1", m_psel, m_penable);
    end
    #2 preset_n = 1'b0;
    #1;
    checks++;
    if (m_psel !== 1'b0 || m_penable !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async_drop: psel=%b pen=%b rv=%b expected 0 0 0", m_psel, m_penable, rsp_valid);
    end
    #2 preset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || m_psel !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_no_rsp: %0d cycles with rsp_valid/psel expected 0", seen);
    end
    send_cmd(1'b1, 32'h020, 32'h00000055);
    run_access(0, 32'h0, 32'h020, pen);
    checks++;
    if (pen != 1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_recover: pen=%0d err=%b to=%b rdata=%h expected 1 0 0 0",
                         pen, rsp_err, rsp_timeout, rsp_rdata);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr();
    test_timeout();
    test_timeout_boundary();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_apb_cmd_master
